// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and widths for the register-file write arbiter and its mul/div result FIFO.
package rf_write_arbiter_pkg;

    localparam int REG_AW = 5;
    localparam int XLEN   = 32;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] waddr;
        logic [XLEN-1:0]   wdata;
    } wb_req_t;

    typedef struct packed {
        logic [REG_AW-1:0] waddr;
        logic [XLEN-1:0]   wdata;
    } md_entry_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO holding mul/div results ({waddr, wdata}) until a free write slot appears.
module rf_wb_fifo
    import rf_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  md_entry_t     push_entry_i,
    input  logic          pop_i,
    output md_entry_t     head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    md_entry_t       mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_entry_i;
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Merges pipeline writeback and mul/div results onto the single register-file write port,
// tracks outstanding mul/div destinations and requests a pipeline bubble when the FIFO starves.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_we,
    input  logic [REG_AW-1:0] pipe_waddr,
    input  logic [XLEN-1:0]   pipe_wdata,
    input  logic              md_valid,
    output logic              md_ready,
    input  logic [REG_AW-1:0] md_waddr,
    input  logic [XLEN-1:0]   md_wdata,
    input  logic              pend_set,
    input  logic [REG_AW-1:0] pend_addr,
    output logic [31:0]       pending,
    output logic              stall_req,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

    wb_req_t         rf_q, rf_d;
    wb_req_t         win_req;
    logic            win_is_md;
    logic [31:0]     pending_q, pending_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            stall_q, stall_d;

    md_entry_t       fifo_head;
    md_entry_t       md_entry;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic            fifo_push;
    logic            fifo_pop;
    logic            md_xfer;
    logic            bypass;

    assign md_entry.waddr = md_waddr;
    assign md_entry.wdata = md_wdata;

    assign md_ready = !fifo_full;
    assign md_xfer  = md_valid && !fifo_full;

    rf_wb_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (fifo_push),
        .push_entry_i (md_entry),
        .pop_i        (fifo_pop),
        .head_o       (fifo_head),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .count_o      (fifo_count)
    );

    // Priority: pipeline, then oldest queued result, then a result arriving into an empty FIFO.
    always_comb begin
        win_req   = '0;
        win_is_md = 1'b0;
        fifo_pop  = 1'b0;
        bypass    = 1'b0;
        if (pipe_we) begin
            win_req.we    = 1'b1;
            win_req.waddr = pipe_waddr;
            win_req.wdata = pipe_wdata;
        end else if (!fifo_empty) begin
            win_req.we    = 1'b1;
            win_req.waddr = fifo_head.waddr;
            win_req.wdata = fifo_head.wdata;
            win_is_md     = 1'b1;
            fifo_pop      = 1'b1;
        end else if (md_xfer) begin
            win_req.we    = 1'b1;
            win_req.waddr = md_waddr;
            win_req.wdata = md_wdata;
            win_is_md     = 1'b1;
            bypass        = 1'b1;
        end
        fifo_push = md_xfer && !bypass;
    end

    // A win to r0 uses up the slot but never asserts the write enable.
    always_comb begin
        rf_d       = rf_q;
        rf_d.we    = win_req.we && (win_req.waddr != REG_ZERO);
        if (win_req.we) begin
            rf_d.waddr = win_req.waddr;
            rf_d.wdata = win_req.wdata;
        end
    end

    // Clear first so a same-cycle re-issue to the same register keeps it pending.
    always_comb begin
        pending_d = pending_q;
        if (win_is_md && (win_req.waddr != REG_ZERO)) begin
            pending_d[win_req.waddr] = 1'b0;
        end
        if (pend_set && (pend_addr != REG_ZERO)) begin
            pending_d[pend_addr] = 1'b1;
        end
    end

    always_comb begin
        starve_d = '0;
        stall_d  = 1'b0;
        if (pipe_we && (fifo_count != '0)) begin
            if (starve_q == SW'(STARVE_LIMIT - 1)) begin
                stall_d = 1'b1;
            end else begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_q      <= '0;
            pending_q <= '0;
            starve_q  <= '0;
            stall_q   <= 1'b0;
        end else begin
            rf_q      <= rf_d;
            pending_q <= pending_d;
            starve_q  <= starve_d;
            stall_q   <= stall_d;
        end
    end

    assign rf_we     = rf_q.we;
    assign rf_waddr  = rf_q.waddr;
    assign rf_wdata  = rf_q.wdata;
    assign pending   = pending_q;
    assign stall_req = stall_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed and randomized checks of rf_write_arbiter against a queue-based reference model.
module tb_rf_write_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 8;

    logic        clk;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_waddr;
    logic [31:0] md_wdata;
    logic        pend_set;
    logic [4:0]  pend_addr;
    logic [31:0] pending;
    logic        stall_req;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    rf_write_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pipe_we    (pipe_we),
        .pipe_waddr (pipe_waddr),
        .pipe_wdata (pipe_wdata),
        .md_valid   (md_valid),
        .md_ready   (md_ready),
        .md_waddr   (md_waddr),
        .md_wdata   (md_wdata),
        .pend_set   (pend_set),
        .pend_addr  (pend_addr),
        .pending    (pending),
        .stall_req  (stall_req),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    int          checks = 0;
    int          errors = 0;

    ent_t        mq[$];
    logic [31:0] m_pend;
    int          m_starve;
    logic        m_stall;
    logic        m_last_xfer;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pend      = '0;
        m_starve    = 0;
        m_stall     = 1'b0;
        m_last_xfer = 1'b0;
        exp_we      = 1'b0;
        exp_addr    = '0;
        exp_data    = '0;
    endtask

    task automatic idle_inputs();
        pipe_we    = 1'b0;
        pipe_waddr = '0;
        pipe_wdata = '0;
        md_valid   = 1'b0;
        md_waddr   = '0;
        md_wdata   = '0;
        pend_set   = 1'b0;
        pend_addr  = '0;
    endtask

    // One clock: predict from the model and current inputs, clock, then compare.
    task automatic cycle();
        bit          ready;
        bit          xfer;
        bit          busy;
        bit          won;
        bit          won_md;
        ent_t        w;
        ready  = (mq.size() < DEPTH);
        xfer   = md_valid && ready;
        busy   = (mq.size() != 0);
        won    = 1'b0;
        won_md = 1'b0;
        m_last_xfer = xfer;
        if (pipe_we) begin
            won = 1'b1;
            w.a = pipe_waddr;
            w.d = pipe_wdata;
        end else if (busy) begin
            won    = 1'b1;
            won_md = 1'b1;
            w      = mq.pop_front();
        end else if (xfer) begin
            won    = 1'b1;
            won_md = 1'b1;
            w.a    = md_waddr;
            w.d    = md_wdata;
            xfer   = 1'b0;
        end
        if (xfer) mq.push_back('{a: md_waddr, d: md_wdata});

        if (pipe_we && busy) begin
            if (m_starve == LIMIT - 1) begin
                m_starve = 0;
                m_stall  = 1'b1;
            end else begin
                m_starve++;
                m_stall = 1'b0;
            end
        end else begin
            m_starve = 0;
            m_stall  = 1'b0;
        end

        if (won_md && w.a != 0) m_pend[w.a] = 1'b0;
        if (pend_set && pend_addr != 0) m_pend[pend_addr] = 1'b1;

        if (won) begin
            exp_we   = (w.a != 0);
            exp_addr = w.a;
            exp_data = w.d;
        end else begin
            exp_we = 1'b0;
        end

        @(posedge clk);
        #1;
        chk("rf_we", rf_we, exp_we);
        if (exp_we) begin
            chk("rf_waddr", rf_waddr, exp_addr);
            chk("rf_wdata", rf_wdata, exp_data);
        end
        chk("pending", pending, m_pend);
        chk("stall_req", stall_req, m_stall);
        chk("md_ready", md_ready, (mq.size() < DEPTH));
    endtask

    // Protocol: no pipe write to a pending register, and none during a stall cycle.
    always @(negedge clk) begin
        if (!reset && pipe_we) begin
            checks++;
            assert (!pending[pipe_waddr] && !stall_req)
            else begin
                errors++;
                $error("FAIL protocol: pipe write r%0d pending=%0d stall=%0d expected neither",
                       pipe_waddr, pending[pipe_waddr], stall_req);
            end
        end
    end

    int stall_pulses;
    int ready_low;
    int sent;
    bit p;

    initial begin
        reset = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rf_we", rf_we, 0);
        chk("reset_rf_waddr", rf_waddr, 0);
        chk("reset_rf_wdata", rf_wdata, 0);
        chk("reset_pending", pending, 0);
        chk("reset_stall", stall_req, 0);
        chk("reset_md_ready", md_ready, 1);
        reset = 1'b0;

        // Plain pipeline write.
        pipe_we = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'h1111_0000;
        cycle();
        chk("t1_waddr", rf_waddr, 5);
        chk("t1_wdata", rf_wdata, 32'h1111_0000);
        idle_inputs();

        // Pending mark then bypassed mul/div write clears it.
        pend_set = 1'b1; pend_addr = 5'd7;
        cycle();
        chk("t2_pend7_set", pending[7], 1);
        idle_inputs();
        md_valid = 1'b1; md_waddr = 5'd7; md_wdata = 32'hDEAD_BEEF;
        cycle();
        chk("t2_bypass_wdata", rf_wdata, 32'hDEAD_BEEF);
        chk("t2_pend7_clear", pending[7], 0);
        idle_inputs();

        // Continuous pipeline traffic starving three queued results.
        stall_pulses = 0;
        ready_low    = 0;
        sent         = 0;
        for (int i = 0; i < 14; i++) begin
            pipe_we    = !m_stall;
            pipe_waddr = 5'd1 + 5'(i % 3);
            pipe_wdata = $urandom;
            md_valid   = (sent < 3);
            md_waddr   = 5'd10 + 5'(sent);
            if (!(md_valid && !m_last_xfer && i != 0)) md_wdata = $urandom;
            cycle();
            if (m_last_xfer) sent++;
            if (stall_req) stall_pulses++;
            if (!md_ready) ready_low++;
        end
        chk("t3_stall_pulses", stall_pulses, 1);
        chk("t3_ready_low_seen", (ready_low > 0), 1);
        idle_inputs();
        for (int i = 0; i < 4; i++) cycle();

        // Same-cycle pipe and mul/div: pipe first, result in the following idle slot.
        pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h3333_3333;
        md_valid = 1'b1; md_waddr = 5'd4; md_wdata = 32'h4444_4444;
        cycle();
        chk("t4_first", rf_waddr, 3);
        idle_inputs();
        cycle();
        chk("t4_second", rf_waddr, 4);

        // Re-issue to r9 in the cycle its earlier result retires keeps it pending.
        pend_set = 1'b1; pend_addr = 5'd9;
        cycle();
        md_valid = 1'b1; md_waddr = 5'd9; md_wdata = 32'h9999_0001;
        cycle();
        chk("t5_pend9_kept", pending[9], 1);
        idle_inputs();
        // r0 result queued behind a pipe write, then consumed without a write.
        pipe_we = 1'b1; pipe_waddr = 5'd2; pipe_wdata = 32'h2222_2222;
        md_valid = 1'b1; md_waddr = 5'd0; md_wdata = 32'h0BAD_0000;
        cycle();
        idle_inputs();
        cycle();
        chk("t5_r0_no_write", rf_we, 0);
        cycle();
        chk("t5_r0_consumed", md_ready, 1);
        md_valid = 1'b1; md_waddr = 5'd9; md_wdata = 32'h9999_0002;
        cycle();
        idle_inputs();

        // Reset with a full FIFO and pending bits.
        pend_set = 1'b1; pend_addr = 5'd20;
        cycle();
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            pipe_we = 1'b1; pipe_waddr = 5'd1; pipe_wdata = $urandom;
            md_valid = 1'b1; md_waddr = 5'd21 + 5'(i); md_wdata = $urandom;
            cycle();
        end
        chk("t6_full_before_reset", md_ready, 0);
        reset = 1'b1;
        idle_inputs();
        #2;
        chk("t6_rst_rf_we", rf_we, 0);
        chk("t6_rst_pending", pending, 0);
        chk("t6_rst_md_ready", md_ready, 1);
        chk("t6_rst_stall", stall_req, 0);
        @(posedge clk);
        #1;
        chk("t6_rst_hold_md_ready", md_ready, 1);
        chk("t6_rst_hold_rf", {rf_we, rf_waddr}, 0);
        reset = 1'b0;
        model_reset();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if (!(md_valid && !m_last_xfer)) begin
                md_valid = ($urandom_range(0, 1) == 1);
                md_waddr = 5'($urandom);
                md_wdata = $urandom;
            end
            p          = ($urandom_range(0, 2) != 0) && !m_stall;
            pipe_waddr = 5'($urandom);
            pipe_wdata = $urandom;
            if (m_pend[pipe_waddr]) p = 1'b0;
            pipe_we    = p;
            pend_set   = ($urandom_range(0, 3) == 0);
            pend_addr  = 5'($urandom);
            cycle();
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
